// File: rtl/alu_arbiter_if.sv
// Bundle of requester, response and shared-ALU signals for alu_arbiter.
// slave : the arbiter side.  master : requesters plus the shared ALU.
interface alu_arbiter_if #(
  parameter int W = 32
);
  logic         req0_valid;
  logic         req1_valid;
  logic         req0_ready;
  logic         req1_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic [3:0]   req0_ctr;
  logic [3:0]   req1_ctr;
  logic         resp0_valid;
  logic         resp1_valid;
  logic         resp0_ready;
  logic         resp1_ready;
  logic [W-1:0] resp_data;
  logic         resp_err;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_ctr;
  logic [W-1:0] alu_res;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_ctr, req1_ctr, resp0_ready, resp1_ready, alu_res,
    output req0_ready, req1_ready, resp0_valid, resp1_valid,
           resp_data, resp_err, alu_a, alu_b, alu_ctr
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_ctr, req1_ctr, resp0_ready, resp1_ready, alu_res,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid,
           resp_data, resp_err, alu_a, alu_b, alu_ctr
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU.
// IDLE grants (round-robin on contention), EXEC presents the latched
// operation to the ALU and captures its result, RESP holds the result
// until the owning requester consumes it.
module alu_arbiter #(
  parameter int W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state_r;
  logic         rr_r;
  logic         id_r;
  logic [W-1:0] alu_a_r;
  logic [W-1:0] alu_b_r;
  logic [3:0]   alu_ctr_r;
  logic [W-1:0] resp_data_r;
  logic         resp_err_r;
  logic         grant0_s;
  logic         grant1_s;
  logic         resp_take_s;

  // Control codes the shared ALU implements.
  function automatic logic ctr_legal(input logic [3:0] ctr);
    logic ok;
    case (ctr)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
      4'b1000, 4'b1010, 4'b1011, 4'b1100: ok = 1'b1;
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Grant decision: only in IDLE and out of reset; rr breaks ties.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if ((state_r == IDLE) && rst_n) begin
      if (bus.req0_valid && bus.req1_valid) begin
        if (rr_r) begin
          grant1_s = 1'b1;
        end else begin
          grant0_s = 1'b1;
        end
      end else if (bus.req0_valid) begin
        grant0_s = 1'b1;
      end else if (bus.req1_valid) begin
        grant1_s = 1'b1;
      end else begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // The owner's resp_ready is the only one that can retire a response.
  always_comb begin
    resp_take_s = 1'b0;
    if (id_r) begin
      resp_take_s = bus.resp1_ready;
    end else begin
      resp_take_s = bus.resp0_ready;
    end
  end

  // Main FSM: accept, execute on the shared ALU, hold the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      rr_r        <= 1'b0;
      id_r        <= 1'b0;
      alu_a_r     <= {W{1'b0}};
      alu_b_r     <= {W{1'b0}};
      alu_ctr_r   <= 4'b0000;
      resp_data_r <= {W{1'b0}};
      resp_err_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant0_s || grant1_s) begin
            id_r      <= grant1_s;
            alu_a_r   <= grant1_s ? bus.req1_a   : bus.req0_a;
            alu_b_r   <= grant1_s ? bus.req1_b   : bus.req0_b;
            alu_ctr_r <= grant1_s ? bus.req1_ctr : bus.req0_ctr;
            rr_r      <= grant0_s;
            state_r   <= EXEC;
          end
        end
        EXEC: begin
          if (ctr_legal(alu_ctr_r)) begin
            resp_data_r <= bus.alu_res;
            resp_err_r  <= 1'b0;
          end else begin
            resp_data_r <= {W{1'b0}};
            resp_err_r  <= 1'b1;
          end
          state_r <= RESP;
        end
        RESP: begin
          if (resp_take_s) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready  = grant0_s;
  assign bus.req1_ready  = grant1_s;
  assign bus.resp0_valid = (state_r == RESP) && !id_r;
  assign bus.resp1_valid = (state_r == RESP) &&  id_r;
  assign bus.resp_data   = resp_data_r;
  assign bus.resp_err    = resp_err_r;
  assign bus.alu_a       = alu_a_r;
  assign bus.alu_b       = alu_b_r;
  assign bus.alu_ctr     = alu_ctr_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a scoreboard queue of expected
// responses filled at every observed grant and drained at every response
// handshake, plus directed timing checks.
module tb_alu_arbiter;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];
  logic        prev_hold;
  logic [31:0] prev_data;
  logic        prev_err;

  alu_arbiter_if #(.W(32)) bus ();

  alu_arbiter #(.W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU; illegal codes yield garbage the DUT must not pass on.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] ctr);
    logic [31:0] r;
    case (ctr)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: r = a + b;
      4'b1010: r = a ^ b;
      4'b1011: r = ~(a | b);
      4'b1100: r = a << b[4:0];
      default: r = 32'hDEAD_BEEF;
    endcase
    return r;
  endfunction

  function automatic logic legal_fn(input logic [3:0] ctr);
    return (ctr == 4'b0000) || (ctr == 4'b0001) || (ctr == 4'b0010) ||
           (ctr == 4'b0110) || (ctr == 4'b0111) || (ctr == 4'b1000) ||
           (ctr == 4'b1010) || (ctr == 4'b1011) || (ctr == 4'b1100);
  endfunction

  function automatic exp_t make_exp(input logic id, input logic [31:0] a,
                                    input logic [31:0] b, input logic [3:0] ctr);
    exp_t e;
    e.id   = id;
    e.err  = !legal_fn(ctr);
    e.data = legal_fn(ctr) ? alu_fn(a, b, ctr) : 32'd0;
    return e;
  endfunction

  // Shared ALU model driven from the arbiter's operand outputs.
  always_comb bus.alu_res = alu_fn(bus.alu_a, bus.alu_b, bus.alu_ctr);

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_flags"}, {59'd0, bus.req0_ready, bus.req1_ready, bus.resp0_valid,
                                bus.resp1_valid, bus.resp_err}, 64'd0);
    check_val({tag, "_data"}, {32'd0, bus.resp_data}, 64'd0);
    check_val({tag, "_alu_a"}, {32'd0, bus.alu_a}, 64'd0);
    check_val({tag, "_alu_b"}, {32'd0, bus.alu_b}, 64'd0);
    check_val({tag, "_alu_ctr"}, {60'd0, bus.alu_ctr}, 64'd0);
  endtask

  // Scoreboard monitor: push on grant, compare while valid, pop on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (bus.req0_ready || bus.req1_ready) begin
        check_val("single_ready", {63'd0, bus.req0_ready & bus.req1_ready}, 64'd0);
        if (bus.req0_ready)
          sb_q.push_back(make_exp(1'b0, bus.req0_a, bus.req0_b, bus.req0_ctr));
        else
          sb_q.push_back(make_exp(1'b1, bus.req1_a, bus.req1_b, bus.req1_ctr));
      end
      if (bus.resp0_valid || bus.resp1_valid) begin
        check_val("single_resp_valid", {63'd0, bus.resp0_valid & bus.resp1_valid}, 64'd0);
        if (prev_hold) begin
          check_val("resp_data_stable", {32'd0, bus.resp_data}, {32'd0, prev_data});
          check_val("resp_err_stable", {63'd0, bus.resp_err}, {63'd0, prev_err});
        end
        if (sb_q.size() == 0) begin
          check_val("resp_unexpected", 64'd1, 64'd0);
          prev_hold = 1'b0;
        end else begin
          check_val("resp_id", {63'd0, bus.resp1_valid}, {63'd0, sb_q[0].id});
          check_val("resp_data", {32'd0, bus.resp_data}, {32'd0, sb_q[0].data});
          check_val("resp_err", {63'd0, bus.resp_err}, {63'd0, sb_q[0].err});
          prev_data = bus.resp_data;
          prev_err  = bus.resp_err;
          if ((bus.resp0_valid && bus.resp0_ready) || (bus.resp1_valid && bus.resp1_ready)) begin
            void'(sb_q.pop_front());
            prev_hold = 1'b0;
          end else begin
            prev_hold = 1'b1;
          end
        end
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  initial begin
    int   g_cnt;
    int   g_cyc[3];
    logic g_id[3];
    n_checks  = 0;
    n_fail    = 0;
    prev_hold = 1'b0;
    prev_data = 32'd0;
    prev_err  = 1'b0;
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_a = 32'd0; bus.req0_b = 32'd0; bus.req0_ctr = 4'd0;
    bus.req1_a = 32'd0; bus.req1_b = 32'd0; bus.req1_ctr = 4'd0;
    bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;

    // Reset with both requesters pending: nothing may be granted.
    repeat (2) next_cycle();
    bus.req0_valid = 1'b1; bus.req0_a = 32'd10; bus.req0_b = 32'd4;  bus.req0_ctr = 4'b0110;
    bus.req1_valid = 1'b1; bus.req1_a = 32'd12; bus.req1_b = 32'd10; bus.req1_ctr = 4'b0000;
    bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
    @(negedge clk);
    check_all_zero("reset");

    // Contention after reset: grants req0, req1, req0, three cycles apart.
    next_cycle();
    rst_n = 1'b1;
    g_cnt = 0;
    for (int c = 0; c < 12 && g_cnt < 3; c++) begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready) begin
        g_id[g_cnt]  = bus.req1_ready;
        g_cyc[g_cnt] = c;
        g_cnt++;
      end
      next_cycle();
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    check_val("rr_grant_count", g_cnt, 64'd3);
    check_val("rr_grant0_id", {63'd0, g_id[0]}, 64'd0);
    check_val("rr_grant1_id", {63'd0, g_id[1]}, 64'd1);
    check_val("rr_grant2_id", {63'd0, g_id[2]}, 64'd0);
    check_val("first_edge_accept", g_cyc[0], 64'd0);
    check_val("throughput_gap1", g_cyc[1] - g_cyc[0], 64'd3);
    check_val("throughput_gap2", g_cyc[2] - g_cyc[1], 64'd3);
    repeat (4) next_cycle();

    // req0 5+3 with code 1000: latency and ALU drive timing.
    bus.req0_valid = 1'b1; bus.req0_a = 32'd5; bus.req0_b = 32'd3; bus.req0_ctr = 4'b1000;
    @(negedge clk);
    check_val("t1_ready_T", {62'd0, bus.req0_ready, bus.req1_ready}, 64'd2);
    next_cycle();
    bus.req0_valid = 1'b0;
    @(negedge clk);
    check_val("t1_alu_ctr_T1", {60'd0, bus.alu_ctr}, 64'h8);
    check_val("t1_alu_a_T1", {32'd0, bus.alu_a}, 64'd5);
    check_val("t1_alu_b_T1", {32'd0, bus.alu_b}, 64'd3);
    check_val("t1_no_valid_T1", {63'd0, bus.resp0_valid}, 64'd0);
    next_cycle();
    @(negedge clk);
    check_val("t1_valid_T2", {62'd0, bus.resp0_valid, bus.resp1_valid}, 64'd2);
    check_val("t1_data_T2", {32'd0, bus.resp_data}, 64'd8);
    check_val("t1_err_T2", {63'd0, bus.resp_err}, 64'd0);
    next_cycle();
    @(negedge clk);
    check_val("t1_idle_T3", {63'd0, bus.resp0_valid}, 64'd0);
    check_val("t1_alu_hold_T3", {60'd0, bus.alu_ctr}, 64'h8);
    next_cycle();

    // req1 OR with a stalled consumer; req0 waits and foreign ready is ignored.
    bus.req1_valid = 1'b1; bus.req1_a = 32'h0000_000F; bus.req1_b = 32'h0000_00F0;
    bus.req1_ctr = 4'b0001; bus.resp1_ready = 1'b0; bus.resp0_ready = 1'b1;
    @(negedge clk);
    check_val("t3_ready1_T", {63'd0, bus.req1_ready}, 64'd1);
    next_cycle();
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 32'd1; bus.req0_b = 32'd1; bus.req0_ctr = 4'b0010;
    @(negedge clk);
    check_val("t3_no_grant_exec", {62'd0, bus.req0_ready, bus.req1_ready}, 64'd0);
    next_cycle();
    @(negedge clk);
    check_val("t3_valid_T2", {63'd0, bus.resp1_valid}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      check_val("t3_hold_valid", {62'd0, bus.resp0_valid, bus.resp1_valid}, 64'd1);
      check_val("t3_hold_data", {32'd0, bus.resp_data}, 64'hFF);
      check_val("t3_hold_no_grant", {62'd0, bus.req0_ready, bus.req1_ready}, 64'd0);
    end
    next_cycle();
    bus.req0_valid = 1'b0; bus.resp1_ready = 1'b1;
    @(negedge clk);
    check_val("t3_release_valid", {63'd0, bus.resp1_valid}, 64'd1);
    next_cycle();
    @(negedge clk);
    check_val("t3_after_release", {63'd0, bus.resp1_valid}, 64'd0);
    next_cycle();

    // Illegal code 0011: error flag, zero data, ALU garbage discarded.
    bus.req0_valid = 1'b1; bus.req0_a = 32'd1; bus.req0_b = 32'd2; bus.req0_ctr = 4'b0011;
    @(negedge clk);
    check_val("t4_ready_T", {63'd0, bus.req0_ready}, 64'd1);
    next_cycle();
    bus.req0_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    check_val("t4_valid_T2", {63'd0, bus.resp0_valid}, 64'd1);
    check_val("t4_err_T2", {63'd0, bus.resp_err}, 64'd1);
    check_val("t4_data_T2", {32'd0, bus.resp_data}, 64'd0);
    next_cycle();
    next_cycle();

    // Reset during EXEC of req1 7-2: operation abandoned, fresh accept at once.
    bus.req1_valid = 1'b1; bus.req1_a = 32'd7; bus.req1_b = 32'd2; bus.req1_ctr = 4'b0110;
    bus.resp1_ready = 1'b1;
    @(negedge clk);
    check_val("t5_ready_T", {63'd0, bus.req1_ready}, 64'd1);
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("t5_reset");
    next_cycle();
    @(negedge clk);
    check_val("t5_no_resp_in_reset", {62'd0, bus.resp0_valid, bus.resp1_valid}, 64'd0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check_val("t5_first_edge_accept", {63'd0, bus.req1_ready}, 64'd1);
    next_cycle();
    bus.req1_valid = 1'b0;
    @(negedge clk);
    check_val("t5_no_stale_resp", {62'd0, bus.resp0_valid, bus.resp1_valid}, 64'd0);
    next_cycle();
    @(negedge clk);
    check_val("t5_resp_valid", {63'd0, bus.resp1_valid}, 64'd1);
    check_val("t5_resp_data", {32'd0, bus.resp_data}, 64'd5);
    next_cycle();
    @(negedge clk);
    check_val("t5_idle", {63'd0, bus.resp1_valid}, 64'd0);

    // Drain: every granted operation must have been answered.
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) next_cycle();
    check_val("scoreboard_empty", sb_q.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
